// File: rtl/rename_map_table_pkg.sv
// rmt_pkg: shared types and helpers for the register rename map table.
//   - rmt_state_e : two-state recovery FSM encoding (RMT_NORMAL, RMT_RECOVER)
//   - rmt_aw/rmt_pw : index widths derived from register file sizes
//   - slot_lsb : lsb of slot/entry <slot> in a flat bus of <width>-bit fields
package rmt_pkg;

  typedef enum logic {
    RMT_NORMAL  = 1'b0,
    RMT_RECOVER = 1'b1
  } rmt_state_e;

  function automatic int rmt_aw(input int archfile_size);
    return $clog2(archfile_size);
  endfunction

  function automatic int rmt_pw(input int physfile_size);
    return $clog2(physfile_size);
  endfunction

  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/rename_map_table_if.sv
// rename_map_table_if: rename/retire/rollback bundle between decode/rename,
// the ROB and the rename map table.
//   master : upstream side (drives requests, receives mappings/status)
//   slave  : the map table itself
// Per-slot fields are packed flat; slot i lives at [i*W +: W].
interface rename_map_table_if
  import rmt_pkg::*;
#(
  parameter int ARCHFILE_SIZE = 32,
  parameter int PHYSFILE_SIZE = 256,
  parameter int REN_WIDTH     = 2,
  parameter int RET_WIDTH     = 2
);
  localparam int AW = rmt_aw(ARCHFILE_SIZE);
  localparam int PW = rmt_pw(PHYSFILE_SIZE);

  logic [REN_WIDTH-1:0]    ren_valid;
  logic [REN_WIDTH*AW-1:0] ren_rs1;
  logic [REN_WIDTH*AW-1:0] ren_rs2;
  logic [REN_WIDTH*AW-1:0] ren_rd;
  logic [REN_WIDTH*PW-1:0] ren_pd;
  logic [REN_WIDTH*PW-1:0] ren_rs1_phys;
  logic [REN_WIDTH*PW-1:0] ren_rs2_phys;
  logic [REN_WIDTH*PW-1:0] ren_rd_oldphys;
  logic                    ren_ready;
  logic [RET_WIDTH-1:0]    ret_valid;
  logic [RET_WIDTH*AW-1:0] ret_rd;
  logic [RET_WIDTH*PW-1:0] ret_pd;
  logic                    rollback;
  logic                    recovering;

  modport master (
    output ren_valid, ren_rs1, ren_rs2, ren_rd, ren_pd,
    output ret_valid, ret_rd, ret_pd, rollback,
    input  ren_rs1_phys, ren_rs2_phys, ren_rd_oldphys, ren_ready, recovering
  );

  modport slave (
    input  ren_valid, ren_rs1, ren_rs2, ren_rd, ren_pd,
    input  ret_valid, ret_rd, ret_pd, rollback,
    output ren_rs1_phys, ren_rs2_phys, ren_rd_oldphys, ren_ready, recovering
  );

endinterface

// File: rtl/rmt_bank.sv
// rmt_bank: ENTRIES x WIDTH map register array, reset to identity.
//   clk, rst   : clock, async active-high reset
//   wr_en/wr_addr/wr_data : NWR write ports, highest port index wins
//   load_en/load_data     : whole-array load, overrides the write ports
//   dump       : flat array image; current state when DUMP_NEXT=0,
//                next state (this cycle's writes applied) when DUMP_NEXT=1
module rmt_bank
  import rmt_pkg::*;
#(
  parameter int ENTRIES   = 32,
  parameter int WIDTH     = 8,
  parameter int NWR       = 2,
  parameter bit DUMP_NEXT = 1'b0,
  parameter int AW        = rmt_aw(ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR*AW-1:0]        wr_addr,
  input  logic [NWR*WIDTH-1:0]     wr_data,
  input  logic                     load_en,
  input  logic [ENTRIES*WIDTH-1:0] load_data,
  output logic [ENTRIES*WIDTH-1:0] dump
);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] mem_d [ENTRIES];

  // Ports are applied in ascending order so the last (highest) one sticks.
  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      for (int e = 0; e < ENTRIES; e++) begin
        mem_d[e] = load_data[slot_lsb(e, WIDTH) +: WIDTH];
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i]) begin
          mem_d[wr_addr[slot_lsb(i, AW) +: AW]] = wr_data[slot_lsb(i, WIDTH) +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) begin
        mem_q[e] <= WIDTH'(e);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_dump
    if (DUMP_NEXT) begin : g_next
      assign dump[e*WIDTH +: WIDTH] = mem_d[e];
    end else begin : g_cur
      assign dump[e*WIDTH +: WIDTH] = mem_q[e];
    end
  end

endmodule

// File: rtl/rename_map_table.sv
// rename_map_table: superscalar speculative / non-speculative rename map.
//   clk, rst : clock, async active-high reset (both maps -> identity)
//   bus      : rename_map_table_if.slave
//     ren_*  : REN_WIDTH rename slots; lookups are combinational with
//              intra-group bypass from lower slots
//     ret_*  : RET_WIDTH retire slots into the non-speculative map
//     rollback/recovering : spec map rebuilt from the non-spec map, then a
//              one-cycle recovery bubble
// Build option: define RMT_ZERO_REG_EN to hardwire arch reg 0 to phys 0.
module rename_map_table
  import rmt_pkg::*;
#(
  parameter int ARCHFILE_SIZE = 32,
  parameter int PHYSFILE_SIZE = 256,
  parameter int REN_WIDTH     = 2,
  parameter int RET_WIDTH     = 2
) (
  input logic               clk,
  input logic               rst,
  rename_map_table_if.slave bus
);

  localparam int AW = rmt_aw(ARCHFILE_SIZE);
  localparam int PW = rmt_pw(PHYSFILE_SIZE);

`ifdef RMT_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  rmt_state_e state_q, state_d;
  logic ren_ready;
  logic [REN_WIDTH-1:0] spec_wr_en;
  logic [RET_WIDTH-1:0] nonspec_wr_en;
  logic [ARCHFILE_SIZE*PW-1:0] spec_dump;
  logic [ARCHFILE_SIZE*PW-1:0] nonspec_next;

  assign ren_ready      = (state_q == RMT_NORMAL) && !bus.rollback;
  assign bus.ren_ready  = ren_ready;
  assign bus.recovering = (state_q == RMT_RECOVER);

  // Rollback reloads spec in either state; RECOVER always lasts at least
  // one cycle after the last rollback pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RMT_NORMAL:  if (bus.rollback) state_d = RMT_RECOVER;
      RMT_RECOVER: state_d = bus.rollback ? RMT_RECOVER : RMT_NORMAL;
      default:     state_d = RMT_NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RMT_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Mapping seen by <slot> for <areg>: the newest older in-group producer,
  // else the committed speculative map.
  function automatic logic [PW-1:0] lookup(input int slot, input logic [AW-1:0] areg);
    logic [PW-1:0] r;
    r = spec_dump[slot_lsb(int'(areg), PW) +: PW];
    for (int k = 0; k < REN_WIDTH; k++) begin
      if (k < slot && bus.ren_valid[k] &&
          bus.ren_rd[slot_lsb(k, AW) +: AW] == areg &&
          !(ZERO_REG && areg == '0)) begin
        r = bus.ren_pd[slot_lsb(k, PW) +: PW];
      end
    end
    if (ZERO_REG && areg == '0) r = '0;
    return r;
  endfunction

  always_comb begin
    bus.ren_rs1_phys   = '0;
    bus.ren_rs2_phys   = '0;
    bus.ren_rd_oldphys = '0;
    for (int j = 0; j < REN_WIDTH; j++) begin
      bus.ren_rs1_phys[slot_lsb(j, PW) +: PW]   = lookup(j, bus.ren_rs1[slot_lsb(j, AW) +: AW]);
      bus.ren_rs2_phys[slot_lsb(j, PW) +: PW]   = lookup(j, bus.ren_rs2[slot_lsb(j, AW) +: AW]);
      bus.ren_rd_oldphys[slot_lsb(j, PW) +: PW] = lookup(j, bus.ren_rd[slot_lsb(j, AW) +: AW]);
    end
  end

  always_comb begin
    spec_wr_en = '0;
    for (int i = 0; i < REN_WIDTH; i++) begin
      spec_wr_en[i] = ren_ready && bus.ren_valid[i] &&
                      !(ZERO_REG && bus.ren_rd[slot_lsb(i, AW) +: AW] == '0);
    end
  end

  always_comb begin
    nonspec_wr_en = '0;
    for (int i = 0; i < RET_WIDTH; i++) begin
      nonspec_wr_en[i] = bus.ret_valid[i] &&
                         !(ZERO_REG && bus.ret_rd[slot_lsb(i, AW) +: AW] == '0);
    end
  end

  // Spec bank reloads from the non-spec next state so same-cycle retires
  // are included in the rebuilt map.
  rmt_bank #(
    .ENTRIES(ARCHFILE_SIZE), .WIDTH(PW), .NWR(REN_WIDTH), .DUMP_NEXT(1'b0), .AW(AW)
  ) u_spec (
    .clk(clk), .rst(rst),
    .wr_en(spec_wr_en), .wr_addr(bus.ren_rd), .wr_data(bus.ren_pd),
    .load_en(bus.rollback), .load_data(nonspec_next),
    .dump(spec_dump)
  );

  rmt_bank #(
    .ENTRIES(ARCHFILE_SIZE), .WIDTH(PW), .NWR(RET_WIDTH), .DUMP_NEXT(1'b1), .AW(AW)
  ) u_nonspec (
    .clk(clk), .rst(rst),
    .wr_en(nonspec_wr_en), .wr_addr(bus.ret_rd), .wr_data(bus.ret_pd),
    .load_en(1'b0), .load_data('0),
    .dump(nonspec_next)
  );

endmodule

// File: tb/tb_rename_map_table.sv
// tb_rename_map_table: directed scenarios followed by random traffic, all
// checked against an array-based model of the two maps and recovery state.
module tb_rename_map_table;

  localparam int ARCH = 32;
  localparam int PHYS = 256;
  localparam int RENW = 2;
  localparam int RETW = 2;
  localparam int AW   = 5;
  localparam int PW   = 8;

`ifdef RMT_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_map_table_if #(
    .ARCHFILE_SIZE(ARCH), .PHYSFILE_SIZE(PHYS), .REN_WIDTH(RENW), .RET_WIDTH(RETW)
  ) bus ();

  rename_map_table #(
    .ARCHFILE_SIZE(ARCH), .PHYSFILE_SIZE(PHYS), .REN_WIDTH(RENW), .RET_WIDTH(RETW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  int spec_m [ARCH];
  int nonspec_m [ARCH];
  bit rec_m;

  function automatic int ren_rd_of(input int s);
    return int'(bus.ren_rd[s*AW +: AW]);
  endfunction

  function automatic int ren_pd_of(input int s);
    return int'(bus.ren_pd[s*PW +: PW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ARCH; i++) begin
      spec_m[i]    = i;
      nonspec_m[i] = i;
    end
    rec_m = 1'b0;
  endtask

  // Newest older valid slot writing areg supplies the mapping.
  function automatic int exp_lookup(input int slot, input int areg);
    if (ZERO && areg == 0) return 0;
    for (int k = slot - 1; k >= 0; k--) begin
      if (bus.ren_valid[k] && ren_rd_of(k) == areg) return ren_pd_of(k);
    end
    return spec_m[areg];
  endfunction

  task automatic model_clock();
    bit ready;
    int rd;
    ready = !rec_m && !bus.rollback;
    if (ready) begin
      for (int s = 0; s < RENW; s++) begin
        rd = ren_rd_of(s);
        if (bus.ren_valid[s] && !(ZERO && rd == 0)) spec_m[rd] = ren_pd_of(s);
      end
    end
    for (int s = 0; s < RETW; s++) begin
      rd = int'(bus.ret_rd[s*AW +: AW]);
      if (bus.ret_valid[s] && !(ZERO && rd == 0)) nonspec_m[rd] = int'(bus.ret_pd[s*PW +: PW]);
    end
    if (bus.rollback) spec_m = nonspec_m;
    rec_m = bus.rollback;
  endtask

  task automatic clear_inputs();
    bus.ren_valid = '0;
    bus.ren_rs1   = '0;
    bus.ren_rs2   = '0;
    bus.ren_rd    = '0;
    bus.ren_pd    = '0;
    bus.ret_valid = '0;
    bus.ret_rd    = '0;
    bus.ret_pd    = '0;
    bus.rollback  = 1'b0;
  endtask

  task automatic set_ren(input int s, input bit v, input int rs1, input int rs2,
                         input int rd, input int pd);
    bus.ren_valid[s]          = v;
    bus.ren_rs1[s*AW +: AW]   = AW'(rs1);
    bus.ren_rs2[s*AW +: AW]   = AW'(rs2);
    bus.ren_rd[s*AW +: AW]    = AW'(rd);
    bus.ren_pd[s*PW +: PW]    = PW'(pd);
  endtask

  task automatic set_ret(input int s, input bit v, input int rd, input int pd);
    bus.ret_valid[s]        = v;
    bus.ret_rd[s*AW +: AW]  = AW'(rd);
    bus.ret_pd[s*PW +: PW]  = PW'(pd);
  endtask

  task automatic applyStimulus();
    for (int s = 0; s < RENW; s++) begin
      set_ren(s, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)));
    end
    for (int s = 0; s < RETW; s++) begin
      set_ret(s, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)));
    end
    bus.rollback = ($urandom_range(0, 9) == 0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    for (int j = 0; j < RENW; j++) begin
      checkOutput($sformatf("%s_rs1_s%0d", tag, j), 32'(bus.ren_rs1_phys[j*PW +: PW]),
                  32'(exp_lookup(j, int'(bus.ren_rs1[j*AW +: AW]))));
      checkOutput($sformatf("%s_rs2_s%0d", tag, j), 32'(bus.ren_rs2_phys[j*PW +: PW]),
                  32'(exp_lookup(j, int'(bus.ren_rs2[j*AW +: AW]))));
      checkOutput($sformatf("%s_old_s%0d", tag, j), 32'(bus.ren_rd_oldphys[j*PW +: PW]),
                  32'(exp_lookup(j, ren_rd_of(j))));
    end
    checkOutput({tag, "_ready"}, 32'(bus.ren_ready), 32'(!rec_m && !bus.rollback));
    checkOutput({tag, "_recovering"}, 32'(bus.recovering), 32'(rec_m));
  endtask

  // Inputs change at negedge; model advances on the same posedge the DUT does.
  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Async reset mid-cycle after dirtying reg 5.
    set_ren(0, 1'b1, 0, 0, 5, 123);
    tick();
    clear_inputs();
    set_ren(0, 1'b0, 5, 5, 5, 0);
    #1;
    checkOutput("pre_rst_r5", 32'(bus.ren_rs1_phys[0 +: PW]), 32'd123);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_r5", 32'(bus.ren_rs1_phys[0 +: PW]), 32'd5);
    checkOutput("rst_recovering", 32'(bus.recovering), 32'd0);
    checkOutput("rst_ready", 32'(bus.ren_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Intra-group bypass.
    clear_inputs();
    set_ren(0, 1'b1, 1, 2, 3, 40);
    set_ren(1, 1'b1, 3, 6, 3, 41);
    #1;
    checkOutput("byp_rs1_s1", 32'(bus.ren_rs1_phys[PW +: PW]), 32'd40);
    checkOutput("byp_old_s1", 32'(bus.ren_rd_oldphys[PW +: PW]), 32'd40);
    checkAll("byp");
    tick();
    clear_inputs();
    set_ren(0, 1'b0, 3, 3, 3, 0);
    #1;
    checkOutput("byp_after_r3", 32'(bus.ren_rs1_phys[0 +: PW]), 32'd41);

    // Same-rd retire conflict, observed through a rollback.
    clear_inputs();
    set_ret(0, 1'b1, 7, 50);
    set_ret(1, 1'b1, 7, 51);
    tick();
    clear_inputs();
    bus.rollback = 1'b1;
    tick();
    clear_inputs();
    set_ren(0, 1'b0, 7, 3, 7, 0);
    #1;
    checkOutput("ret_conflict_r7", 32'(bus.ren_rs1_phys[0 +: PW]), 32'd51);
    checkOutput("ret_conflict_r3", 32'(bus.ren_rs2_phys[0 +: PW]), 32'd3);
    checkAll("ret_conflict");
    tick();

    // Rollback with same-cycle retire; the rename is dropped.
    clear_inputs();
    set_ren(0, 1'b1, 0, 0, 4, 60);
    set_ret(0, 1'b1, 4, 55);
    bus.rollback = 1'b1;
    #1;
    checkOutput("rb_T_ready", 32'(bus.ren_ready), 32'd0);
    tick();
    clear_inputs();
    set_ren(0, 1'b0, 4, 4, 4, 0);
    #1;
    checkOutput("rb_T1_r4", 32'(bus.ren_rs1_phys[0 +: PW]), 32'd55);
    checkOutput("rb_T1_ready", 32'(bus.ren_ready), 32'd0);
    checkOutput("rb_T1_recovering", 32'(bus.recovering), 32'd1);
    tick();
    #1;
    checkOutput("rb_T2_ready", 32'(bus.ren_ready), 32'd1);
    checkOutput("rb_T2_recovering", 32'(bus.recovering), 32'd0);

    // Back-to-back rollback.
    clear_inputs();
    bus.rollback = 1'b1;
    tick();
    #1;
    checkOutput("b2b_T1_recovering", 32'(bus.recovering), 32'd1);
    tick();
    clear_inputs();
    set_ren(0, 1'b1, 9, 9, 9, 77);
    #1;
    checkOutput("b2b_T2_recovering", 32'(bus.recovering), 32'd1);
    checkOutput("b2b_T2_ready", 32'(bus.ren_ready), 32'd0);
    tick();
    clear_inputs();
    set_ren(0, 1'b1, 9, 9, 9, 78);
    #1;
    checkOutput("b2b_T3_ready", 32'(bus.ren_ready), 32'd1);
    checkOutput("b2b_T3_r9", 32'(bus.ren_rs1_phys[0 +: PW]), 32'd9);
    tick();
    clear_inputs();
    set_ren(0, 1'b0, 9, 9, 9, 0);
    #1;
    checkOutput("b2b_after_r9", 32'(bus.ren_rs1_phys[0 +: PW]), 32'd78);

    // Reg 0 handling.
    clear_inputs();
    set_ren(0, 1'b1, 1, 1, 0, 99);
    set_ren(1, 1'b0, 0, 0, 2, 0);
    #1;
    checkOutput("zero_byp_s1", 32'(bus.ren_rs1_phys[PW +: PW]), ZERO ? 32'd0 : 32'd99);
    checkAll("zero");
    tick();
    clear_inputs();
    set_ren(0, 1'b0, 0, 0, 0, 0);
    #1;
    checkOutput("zero_after_r0", 32'(bus.ren_rs1_phys[0 +: PW]), ZERO ? 32'd0 : 32'd99);

    // Async reset while in RECOVER.
    clear_inputs();
    bus.rollback = 1'b1;
    tick();
    clear_inputs();
    set_ren(0, 1'b0, 9, 0, 0, 0);
    #1;
    checkOutput("rstrec_pre_recovering", 32'(bus.recovering), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstrec_recovering", 32'(bus.recovering), 32'd0);
    checkOutput("rstrec_ready", 32'(bus.ren_ready), 32'd1);
    checkOutput("rstrec_r9", 32'(bus.ren_rs1_phys[0 +: PW]), 32'd9);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      applyStimulus();
      #1;
      checkAll($sformatf("rand%0d", n));
      tick();
    end

    clear_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_map_table.md
# rename_map_table

Superscalar register rename map for the out-of-order backend. It holds two maps from architectural to physical register:
- a speculative map, updated by REN_WIDTH rename slots per cycle;
- a non-speculative map, updated by RET_WIDTH retire slots per cycle.

On rollback, the speculative map is rebuilt from the non-speculative map, followed by a one-cycle recovery bubble. It sits between decode/rename and the ROB and replaces the single-port arch/phys map pair.

## Interface
Parameters:
- ARCHFILE_SIZE, 32, architectural register count (power of two)
- PHYSFILE_SIZE, 256, physical register count (power of two)
- REN_WIDTH, 2, rename slots per cycle (1–4)
- RET_WIDTH, 2, retire slots per cycle (1–4)

Widths: AW = $clog2(ARCHFILE_SIZE), PW = $clog2(PHYSFILE_SIZE).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ren_valid  in  REN_WIDTH  per-slot rename request
- ren_rs1, ren_rs2, ren_rd  in  REN_WIDTH*AW  per-slot source/destination arch regs; slot i at [i*AW +: AW]
- ren_pd  in  REN_WIDTH*PW  new physical reg for ren_rd
- ren_rs1_phys, ren_rs2_phys, ren_rd_oldphys  out  REN_WIDTH*PW  per-slot mappings (combinational)
- ren_ready  out  1  rename accepted this cycle
- ret_valid  in  RET_WIDTH  per-slot retire update
- ret_rd  in  RET_WIDTH*AW  retiring arch reg
- ret_pd  in  RET_WIDTH*PW  committed physical reg
- rollback  in  1  flush request; single-cycle pulse
- recovering  out  1  high in RECOVER state

## Operation
- **Reset.** Both maps are set to identity (entry i = i). State = NORMAL, recovering = 0, ren_ready = 1.
- **Read path.** Outputs are combinational. For slot j, each source and ren_rd_oldphys takes ren_pd of the highest-index slot k<j with ren_valid[k] and ren_rd[k] equal to that operand. With no such slot, it reads the speculative map. Outputs are driven regardless of ren_valid.
- **Rename write.** When ren_ready and ren_valid[i] are both high, spec[ren_rd[i]] <= ren_pd[i]. If several slots name the same rd, the highest index wins.
- **ren_ready** = (state == NORMAL) && !rollback. A rename presented while ren_ready = 0 is dropped; the upstream stage holds it.
- **Retire write.** nonspec[ret_rd[i]] <= ret_pd[i] for each valid slot, in every state, including the rollback cycle. If several slots name the same rd, the highest index wins.
- **FSM, two states.**
  - NORMAL, rollback = 1: spec <= next non-spec map (includes this cycle's retire writes); go to RECOVER.
  - RECOVER, rollback = 0: go to NORMAL.
  - RECOVER, rollback = 1: copy again; stay in RECOVER.
  - recovering = (state == RECOVER).
- **Async reset mid-recovery** returns the block to NORMAL with identity maps.

## Timing
- Rename lookup: 0 cycles. Rename and retire writes are visible to reads the cycle after the edge.
- Rollback asserted in cycle T:
  - renames in T are dropped;
  - the spec map equals the non-spec map after edge T;
  - T+1 is RECOVER, with ren_ready = 0;
  - renames are accepted again from T+2.
- A retire in cycle T is visible in the rebuilt spec map at T+1.

## Configuration
RMT_ZERO_REG_EN.
- **Defined.** Arch reg 0 is hardwired to phys 0:
  - rename and retire writes to rd = 0 are ignored;
  - intra-group bypass never matches rd = 0;
  - reads of reg 0, and ren_rd_oldphys when rd = 0, return 0.
- **Undefined.** Reg 0 is renamed like any other register.

## Structure
- Package rmt_pkg holds:
  - AW/PW helper functions;
  - the state enum (RMT_NORMAL, RMT_RECOVER);
  - slot slice helpers.
- Sub-module rmt_bank: a flat ARCHFILE_SIZE×PW register array with:
  - N write ports, highest port index wins on conflict;
  - a full-array load port;
  - flat dump output.
- rename_map_table instantiates rmt_bank twice:
  - speculative: REN_WIDTH write ports, with the load port fed from the non-spec bank's next-state dump;
  - non-speculative: RET_WIDTH write ports.

## Test plan
- **Reset.** Assert rst asynchronously mid-cycle -> ren_rs1_phys for rs1 = 5 reads 5; recovering = 0; ren_ready = 1.
- **Intra-group bypass.** Slot0 rd = 3, pd = 40; slot1 rs1 = 3, rd = 3, pd = 41 -> slot1 rs1_phys = 40, slot1 rd_oldphys = 40; next cycle, a read of reg 3 = 41.
- **Same-rd conflict.** Two retire slots with rd = 7, pd = 50 and 51 -> nonspec[7] = 51.
- **Rollback with same-cycle retire.** Rename r4 -> 60; retire r4 -> 55 in the same cycle as rollback -> rename dropped; T+1: r4 reads 55, ren_ready = 0, recovering = 1; T+2: ren_ready = 1.
- **Back-to-back rollback.** Rollback in T and T+1 -> recovering stays high through T+2; renames accepted from T+3.
- **Zero reg.** With RMT_ZERO_REG_EN, rename rd = 0 with pd = 99 -> reg 0 still reads 0, and slot1 rs1 = 0 returns 0. Without the macro, reg 0 reads 99.
